fb_arbiter: RTL

- Shares the single frame-buffer memory slave port between two masters: the video pixel DMA (read-only, real-time) and the CPU data port (read/write).
- Sits in the memory clock domain between the video core's fb_* master interface and the SRAM/SDRAM controller.
- Supports pipelined reads with waitrequest/readdatavalid.
- Returns each read datum to its issuer through an in-order tag FIFO.

---
 rtl/fb_arb_pkg.sv | 14 +
 rtl/fb_arb_tag_fifo.sv | 42 ++++
 rtl/fb_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fb_arb_pkg.sv
// Shared constants and types for the frame-buffer arbiter.
// Tags record which master issued each outstanding read.
package fb_arb_pkg;
  localparam int DEF_AW = 30;
  localparam int DEF_DW = 32;

  localparam logic TAG_VID = 1'b0;
  localparam logic TAG_CPU = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } lock_state_t;
endpackage

// File: rtl/fb_arb_tag_fifo.sv
// In-order 1-bit tag FIFO recording the issuer of each outstanding read.
// A push while full is taken only when a pop frees the head slot in the same cycle.
module fb_arb_tag_fifo #(
  parameter int DEPTH = 8
) (
  input  logic memory_clock,
  input  logic reset_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge memory_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (PW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end
endmodule

// File: rtl/fb_arbiter.sv
// Two-master arbiter for the frame-buffer slave: real-time video reads and CPU read/write.
// state | meaning
// IDLE  | grant decided every cycle from the requests
// LOCK  | a stalled command is held; grant stays with owner until accepted
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int TAG_DEPTH  = 8,
  parameter int STARVE_MAX = 16
) (
  input  logic            memory_clock,
  input  logic            reset_n,
  input  logic [AW-1:0]   vid_address,
  input  logic            vid_read,
  output logic            vid_waitrequest,
  output logic [DW-1:0]   vid_readdata,
  output logic            vid_readdatavalid,
  input  logic [AW-1:0]   cpu_address,
  input  logic            cpu_read,
  input  logic            cpu_write,
  input  logic [DW-1:0]   cpu_writedata,
  input  logic [DW/8-1:0] cpu_byteenable,
  output logic            cpu_waitrequest,
  output logic [DW-1:0]   cpu_readdata,
  output logic            cpu_readdatavalid,
  output logic [AW-1:0]   s_address,
  output logic            s_read,
  output logic            s_write,
  output logic [DW-1:0]   s_writedata,
  output logic [DW/8-1:0] s_byteenable,
  input  logic            s_waitrequest,
  input  logic [DW-1:0]   s_readdata,
  input  logic            s_readdatavalid
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  lock_state_t state, state_nxt;
  logic          owner, owner_nxt;
  logic [SW-1:0] starve, starve_nxt;

  logic fifo_full, fifo_empty, fifo_head, fifo_push;
  logic tag_stall, vid_elig, cpu_req, cpu_elig;
  logic gnt, gnt_valid, present, accept, cpu_acc;
  logic          rdv_vid_q, rdv_cpu_q;
  logic [DW-1:0] rdata_q;

  // A pop in the same cycle frees a slot, so a full FIFO only stalls without a response.
  assign tag_stall = fifo_full && !s_readdatavalid;
  assign vid_elig  = vid_read && !tag_stall;
  assign cpu_req   = cpu_read || cpu_write;
  assign cpu_elig  = cpu_write || (cpu_read && !tag_stall);
  assign present   = s_read || s_write;
  assign accept    = present && !s_waitrequest;
  assign cpu_acc   = accept && (gnt == TAG_CPU);
  assign fifo_push = accept && s_read;

  always_ff @(posedge memory_clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      owner  <= TAG_VID;
      starve <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      starve <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    starve_nxt = starve;
    case (state)
      ST_IDLE: if (present && s_waitrequest) state_nxt = ST_LOCK;
      ST_LOCK: if (accept) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (present) owner_nxt = gnt;
    if (!cpu_req || cpu_acc) starve_nxt = '0;
    else if (starve != SW'(STARVE_MAX)) starve_nxt = starve + SW'(1);
  end

  // Command path is purely combinational; reset gates it so nothing reaches the slave.
  always_comb begin
    gnt       = owner;
    gnt_valid = 1'b0;
    if (state == ST_LOCK) begin
      gnt_valid = 1'b1;
    end else if (cpu_elig && starve == SW'(STARVE_MAX)) begin
      gnt       = TAG_CPU;
      gnt_valid = 1'b1;
    end else if (vid_elig) begin
      gnt       = TAG_VID;
      gnt_valid = 1'b1;
    end else if (cpu_elig) begin
      gnt       = TAG_CPU;
      gnt_valid = 1'b1;
    end
    s_address    = (gnt == TAG_CPU) ? cpu_address : vid_address;
    s_writedata  = cpu_writedata;
    s_byteenable = (gnt == TAG_CPU) ? cpu_byteenable : '1;
    s_read       = 1'b0;
    s_write      = 1'b0;
    if (reset_n && gnt_valid) begin
      if (gnt == TAG_CPU) begin
        s_read  = cpu_read && !tag_stall;
        s_write = cpu_write;
      end else begin
        s_read  = vid_read && !tag_stall;
      end
    end
    vid_waitrequest = !(accept && gnt == TAG_VID);
    cpu_waitrequest = !(accept && gnt == TAG_CPU);
  end

  fb_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .memory_clock (memory_clock),
    .reset_n      (reset_n),
    .push         (fifo_push),
    .din          (gnt),
    .pop          (s_readdatavalid),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .head         (fifo_head)
  );

  always_ff @(posedge memory_clock or negedge reset_n) begin
    if (!reset_n) begin
      rdv_vid_q <= 1'b0;
      rdv_cpu_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rdv_vid_q <= s_readdatavalid && !fifo_empty && (fifo_head == TAG_VID);
      rdv_cpu_q <= s_readdatavalid && !fifo_empty && (fifo_head == TAG_CPU);
      if (s_readdatavalid) rdata_q <= s_readdata;
    end
  end

  assign vid_readdata      = rdata_q;
  assign cpu_readdata      = rdata_q;
  assign vid_readdatavalid = rdv_vid_q;
  assign cpu_readdatavalid = rdv_cpu_q;

`ifndef SYNTHESIS
  rdv_without_tag: assert property (@(posedge memory_clock) disable iff (!reset_n)
    !(s_readdatavalid && fifo_empty));
`endif
endmodule
